// File: rtl/rns_to_binary_mrc.sv
// ---------------------------------------------------------------------------
// rns_to_binary_mrc
//   Sequential reverse converter for the {7,5,3} residue number system.
//   Turns a residue triple back into a binary integer 0..104 by mixed-radix
//   conversion:  X = a1 + 7*a2 + 35*a3
//     a1 = r1
//     a2 = ((r2 - a1) * inv(7 mod 5)) mod 5,   inv = 3
//     a3 = (((r3 - a1) * inv(7 mod 3) - a2) * inv(5 mod 3)) mod 3,  inv = 1, 2
//   One digit per cycle: IDLE -> MR2 -> MR3 -> SUM -> DONE -> IDLE.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   residue triple present          in_ready  high only in IDLE
//   r1/r2/r3   residues mod 7 / 5 / 3 (3 bits each, may be out of range)
//   out_valid  result present, held until out_ready
//   out_ready  downstream accepts result
//   out_data   binary result 0..104 (0 on error)
//   out_err    some residue was out of its legal range
// ---------------------------------------------------------------------------
module rns_to_binary_mrc (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] r1,
    input  logic [2:0] r2,
    input  logic [2:0] r3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_data,
    output logic       out_err
);

    typedef enum logic [2:0] {IDLE, MR2, MR3, SUM, DONE} state_t;

    typedef struct packed {
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] r3;
    } res_t;

    state_t     state;
    res_t       res_q;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [1:0] a3;
    logic       err_q;

    // Small constant-modulus reducers by conditional subtraction. Every
    // operand fed to them is kept non-negative and below 16.
    function automatic logic [2:0] mod5(input logic [3:0] x);
        logic [3:0] y;
        y = x;
        if (y >= 4'd10) y = y - 4'd10;
        if (y >= 4'd5)  y = y - 4'd5;
        if (y >= 4'd5)  y = y - 4'd5;
        return y[2:0];
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] x);
        logic [3:0] y;
        y = x;
        if (y >= 4'd9) y = y - 4'd9;
        if (y >= 4'd6) y = y - 4'd6;
        if (y >= 4'd3) y = y - 4'd3;
        return y[1:0];
    endfunction

    // Digit a2: reduce a1 mod 5 first, then add 5 so the difference with r2
    // can never go negative before the final reduction.
    logic [2:0] a1_m5;
    logic [2:0] d2;
    logic [2:0] a2_nxt;

    always_comb begin
        a1_m5  = mod5({1'b0, a1});
        d2     = mod5({1'b0, res_q.r2} + 4'd5 - {1'b0, a1_m5});
        a2_nxt = mod5({1'b0, d2} * 4'd3);
    end

    // Digit a3: same non-negative trick with a bias of 3. inv(7 mod 3)=1 so
    // the first product is just t.
    logic [1:0] a1_m3;
    logic [1:0] a2_m3;
    logic [1:0] t3;
    logic [1:0] u3;
    logic [1:0] a3_nxt;

    always_comb begin
        a1_m3  = mod3({1'b0, a1});
        a2_m3  = mod3({1'b0, a2});
        t3     = mod3({1'b0, res_q.r3} + 4'd3 - {2'b00, a1_m3});
        u3     = mod3({2'b00, t3} + 4'd3 - {2'b00, a2_m3});
        a3_nxt = mod3({2'b00, u3} * 4'd2);
    end

    // Final weighted sum; max 6 + 7*4 + 35*2 = 104 fits in 7 bits.
    logic [6:0] sum_nxt;

    always_comb begin
        sum_nxt = {4'd0, a1} + 7'd7 * {4'd0, a2} + 7'd35 * {5'd0, a3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 7'd0;
            out_err   <= 1'b0;
            res_q     <= '0;
            a1        <= 3'd0;
            a2        <= 3'd0;
            a3        <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        res_q    <= '{r1: r1, r2: r2, r3: r3};
                        a1       <= r1;
                        err_q    <= (r1 > 3'd6) || (r2 > 3'd4) || (r3 > 3'd2);
                        in_ready <= 1'b0;
                        state    <= MR2;
                    end
                end
                MR2: begin
                    a2    <= a2_nxt;
                    state <= MR3;
                end
                MR3: begin
                    a3    <= a3_nxt;
                    state <= SUM;
                end
                SUM: begin
                    // Errors keep the normal latency, just with a zeroed result.
                    out_data  <= err_q ? 7'd0 : sum_nxt;
                    out_err   <= err_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // out_data/out_err keep their value after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
